// File: rtl/cmd_id_receiver_pkg.sv
// Shared types and constants for the command/ID serial front-end.
package cmd_id_receiver_pkg;

  // UART frame: start + 8 data + stop samples
  localparam int unsigned UART_FRAME_BITS = 10;
  // Barcode frame: data bits following the start bit
  localparam int unsigned BC_DATA_BITS = 8;

  typedef enum logic {
    UART_IDLE,
    UART_RECV
  } uart_state_t;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_MEAS_START,
    BC_WAIT_FALL,
    BC_TIMING
  } bc_state_t;

  // Station IDs only occupy the lower six bits; anything else is a misread.
  function automatic logic id_is_valid(input logic [7:0] id);
    return id[7:6] == 2'b00;
  endfunction

endpackage

// File: rtl/cmd_id_receiver_if.sv
// Consumer-facing handshake bundle: command byte and station ID with their clears.
interface cmd_id_receiver_if;
  logic       rx_rdy_clr;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_ID_vld;
  logic       ID_vld;
  logic [7:0] ID;

  modport master (
    input  rx_rdy_clr, clr_ID_vld,
    output rx_rdy, rx_data, ID_vld, ID
  );

  modport slave (
    output rx_rdy_clr, clr_ID_vld,
    input  rx_rdy, rx_data, ID_vld, ID
  );
endinterface

// File: rtl/cmd_id_receiver_bc_rx.sv
// Self-clocking barcode reader: start bit sets the half-period, data sampled MSB first.
module cmd_id_bc_rx
  import cmd_id_receiver_pkg::*;
#(
  parameter int unsigned BC_CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bc,
  input  logic       clr_id_vld,
  output logic       id_vld,
  output logic [7:0] id
);

  logic                bc_meta, bc_sync, bc_prev;
  logic                bc_fall, bc_rise;
  bc_state_t           state, state_nxt;
  logic [BC_CNT_W-1:0] cnt;
  logic [BC_CNT_W-1:0] half_period;
  logic [2:0]          bit_cnt;
  logic [6:0]          shift;
  logic [7:0]          byte_nxt;
  logic                clr_cnt, latch_half, sample, frame_done;

  assign bc_fall  = bc_prev & ~bc_sync;
  assign bc_rise  = ~bc_prev & bc_sync;
  // Only seven bits are stored; the eighth joins on the final sample.
  assign byte_nxt = {shift, bc_sync};

  // Two-flop synchronizer plus one delay flop for edge detection, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_meta <= 1'b1;
      bc_sync <= 1'b1;
      bc_prev <= 1'b1;
    end else begin
      bc_meta <= bc;
      bc_sync <= bc_meta;
      bc_prev <= bc_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BC_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    clr_cnt    = 1'b0;
    latch_half = 1'b0;
    sample     = 1'b0;
    frame_done = 1'b0;
    case (state)
      BC_IDLE: begin
        clr_cnt = 1'b1;
        if (bc_fall) state_nxt = BC_MEAS_START;
      end
      BC_MEAS_START: begin
        if (bc_rise) begin
          latch_half = 1'b1;
          clr_cnt    = 1'b1;
          state_nxt  = BC_WAIT_FALL;
        end
      end
      BC_WAIT_FALL: begin
        clr_cnt = 1'b1;
        if (bc_fall) state_nxt = BC_TIMING;
      end
      BC_TIMING: begin
        if (cnt == half_period) begin
          sample  = 1'b1;
          clr_cnt = 1'b1;
          if (bit_cnt == 3'(BC_DATA_BITS - 1)) begin
            frame_done = 1'b1;
            state_nxt  = BC_IDLE;
          end else begin
            state_nxt  = BC_WAIT_FALL;
          end
        end
      end
      default: state_nxt = BC_IDLE;
    endcase
  end

  // Saturating timing counter, half-period latch, bit counter and shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      half_period <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
    end else begin
      if (clr_cnt)        cnt <= '0;
      else if (cnt != '1) cnt <= cnt + BC_CNT_W'(1);
      if (latch_half) begin
        half_period <= cnt;
        bit_cnt     <= '0;
      end
      if (sample) begin
        shift   <= byte_nxt[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Station ID and valid flag; a valid completion takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_vld <= 1'b0;
      id     <= '0;
    end else if (frame_done && id_is_valid(byte_nxt)) begin
      id_vld <= 1'b1;
      id     <= byte_nxt;
    end else if (clr_id_vld) begin
      id_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_id_receiver_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, result held until cleared.
module cmd_id_uart_rx
  import cmd_id_receiver_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_rdy_clr,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV + 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2);

  logic              rx_meta, rx_sync, rx_prev;
  logic              rx_fall;
  uart_state_t       state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [8:0]        shift;
  logic [8:0]        shift_nxt;
  logic              start_frame, bit_tick, frame_done;
  logic              start_bit_unused;

  assign rx_fall          = rx_prev & ~rx_sync;
  assign shift_nxt        = {rx_sync, shift[8:1]};
  // The start bit falls off the bottom of the 9-bit shifter.
  assign start_bit_unused = shift[0];

  // Two-flop synchronizer plus one delay flop for edge detection, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UART_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    bit_tick    = 1'b0;
    frame_done  = 1'b0;
    case (state)
      UART_IDLE: begin
        if (rx_fall) begin
          start_frame = 1'b1;
          state_nxt   = UART_RECV;
        end
      end
      UART_RECV: begin
        if (baud_cnt <= BAUD_W'(1)) begin
          bit_tick = 1'b1;
          if (bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
            frame_done = 1'b1;
            state_nxt  = UART_IDLE;
          end
        end
      end
      default: state_nxt = UART_IDLE;
    endcase
  end

  // Baud timer, sample counter and shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (start_frame) begin
      baud_cnt <= BAUD_HALF;
      bit_cnt  <= '0;
    end else if (state == UART_RECV) begin
      if (bit_tick) begin
        baud_cnt <= BAUD_FULL;
        bit_cnt  <= bit_cnt + 4'd1;
        shift    <= shift_nxt;
      end else begin
        baud_cnt <= baud_cnt - BAUD_W'(1);
      end
    end
  end

  // Output byte and ready flag; completion takes priority over any clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy  <= 1'b0;
      rx_data <= '0;
    end else if (frame_done) begin
      rx_rdy  <= 1'b1;
      rx_data <= shift_nxt[7:0];
    end else if (rx_rdy_clr || start_frame) begin
      rx_rdy  <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_id_receiver.sv
// Serial front-end: UART command receiver and barcode station-ID reader side by side.
module cmd_id_receiver #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned BC_CNT_W = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  input  logic               BC,
  cmd_id_receiver_if.master  bus
);

  cmd_id_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (RX),
    .rx_rdy_clr (bus.rx_rdy_clr),
    .rx_rdy     (bus.rx_rdy),
    .rx_data    (bus.rx_data)
  );

  cmd_id_bc_rx #(
    .BC_CNT_W (BC_CNT_W)
  ) u_bc_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .bc         (BC),
    .clr_id_vld (bus.clr_ID_vld),
    .id_vld     (bus.ID_vld),
    .id         (bus.ID)
  );

endmodule

// File: tb/tb_cmd_id_receiver.sv
// Directed plus randomized bench for cmd_id_receiver with a frame-level reference model.
module tb_cmd_id_receiver;

  localparam int unsigned BAUD_DIV = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic RX;
  logic BC;

  int checks = 0;
  int errors = 0;

  // Reference model: what each output should read, derived from frames sent.
  logic       exp_rdy;
  logic [7:0] exp_data;
  logic       exp_vld;
  logic [7:0] exp_id;

  logic        seen;
  logic [7:0]  got;
  int unsigned poll_n;
  logic [7:0]  b;
  int unsigned period;

  cmd_id_receiver_if bus ();

  cmd_id_receiver #(
    .BAUD_DIV (BAUD_DIV),
    .BC_CNT_W (22)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .BC    (BC),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_uart(input string tag);
    check1({tag, "_rx_rdy"}, bus.rx_rdy, exp_rdy);
    check8({tag, "_rx_data"}, bus.rx_data, exp_data);
  endtask

  task automatic check_bc(input string tag);
    check1({tag, "_ID_vld"}, bus.ID_vld, exp_vld);
    check8({tag, "_ID"}, bus.ID, exp_id);
  endtask

  // One 8N1 frame; optionally checks that a pending byte was dropped by the start bit.
  task automatic uart_send(input logic [7:0] data, input bit chk_start);
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    if (chk_start) begin
      exp_rdy = 1'b0;
      check1("uart_start_clears_rdy", bus.rx_rdy, exp_rdy);
    end
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  // One barcode frame: start bit then 8 data bits MSB first.
  task automatic bc_send(input logic [7:0] data, input int unsigned per);
    BC = 1'b0;
    repeat (per / 2) @(negedge clk);
    BC = 1'b1;
    repeat (per / 2) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      BC = 1'b0;
      repeat (data[i] ? per / 4 : 3 * per / 4) @(negedge clk);
      BC = 1'b1;
      repeat (data[i] ? 3 * per / 4 : per / 4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic model_uart(input logic [7:0] data);
    exp_rdy  = 1'b1;
    exp_data = data;
  endtask

  task automatic model_bc(input logic [7:0] data);
    if (data[7:6] == 2'b00) begin
      exp_vld = 1'b1;
      exp_id  = data;
    end
  endtask

  task automatic pulse_rx_clr();
    bus.rx_rdy_clr = 1'b1;
    @(negedge clk);
    bus.rx_rdy_clr = 1'b0;
    exp_rdy = 1'b0;
  endtask

  task automatic pulse_id_clr();
    bus.clr_ID_vld = 1'b1;
    @(negedge clk);
    bus.clr_ID_vld = 1'b0;
    exp_vld = 1'b0;
  endtask

  initial begin
    RX = 1'b1;
    BC = 1'b1;
    bus.rx_rdy_clr = 1'b0;
    bus.clr_ID_vld = 1'b0;
    exp_rdy = 1'b0; exp_data = 8'h00; exp_vld = 1'b0; exp_id = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_uart("reset");
    check_bc("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // UART single byte then clear
    uart_send(8'h42, 1'b1);
    model_uart(8'h42);
    check_uart("uart_42");
    pulse_rx_clr();
    check_uart("uart_42_clr");

    // UART back-to-back without clearing
    uart_send(8'h40, 1'b1);
    model_uart(8'h40);
    check_uart("uart_40");
    uart_send(8'hC0, 1'b1);
    model_uart(8'hC0);
    check_uart("uart_C0");

    // Clear held across completion: ready must still show for a cycle
    bus.rx_rdy_clr = 1'b1;
    @(negedge clk);
    seen = 1'b0; got = 8'h00; poll_n = 0;
    fork
      uart_send(8'hA7, 1'b0);
      begin
        while (!bus.rx_rdy && poll_n < 11 * BAUD_DIV) begin
          @(negedge clk);
          poll_n++;
        end
        seen = bus.rx_rdy;
        got  = bus.rx_data;
      end
    join
    check1("uart_set_beats_clr_seen", seen, 1'b1);
    check8("uart_set_beats_clr_data", got, 8'hA7);
    exp_rdy = 1'b0; exp_data = 8'hA7;
    check_uart("uart_held_clr");
    bus.rx_rdy_clr = 1'b0;

    // Randomized UART bytes
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      uart_send(b, 1'b1);
      model_uart(b);
      check_uart("uart_rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_rx_clr();
        check_uart("uart_rand_clr");
      end
    end

    // Barcode at period 1000
    bc_send(8'h06, 1000);
    model_bc(8'h06);
    check_bc("bc_06");
    pulse_id_clr();
    check_bc("bc_06_clr");

    // Barcode sequence with clears between
    foreach (b[i]) begin end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: b = 8'h0F;
        1: b = 8'h00;
        2: b = 8'h0A;
        default: b = 8'h02;
      endcase
      bc_send(b, 200);
      model_bc(b);
      check_bc("bc_seq");
      pulse_id_clr();
      check_bc("bc_seq_clr");
    end

    // Invalid upper bits are discarded, next valid ID still received
    bc_send(8'hC5, 200);
    model_bc(8'hC5);
    check_bc("bc_C5_discard");
    bc_send(8'h02, 200);
    model_bc(8'h02);
    check_bc("bc_02_after_bad");

    // Clear held across completion
    bus.clr_ID_vld = 1'b1;
    @(negedge clk);
    seen = 1'b0; got = 8'h00; poll_n = 0;
    fork
      bc_send(8'h15, 200);
      begin
        while (!bus.ID_vld && poll_n < 2000) begin
          @(negedge clk);
          poll_n++;
        end
        seen = bus.ID_vld;
        got  = bus.ID;
      end
    join
    check1("bc_set_beats_clr_seen", seen, 1'b1);
    check8("bc_set_beats_clr_id", got, 8'h15);
    exp_vld = 1'b0; exp_id = 8'h15;
    check_bc("bc_held_clr");
    bus.clr_ID_vld = 1'b0;

    // Randomized barcode frames and periods
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[7:6] = 2'b00;
      period = 4 * $urandom_range(40, 100);
      bc_send(b, period);
      model_bc(b);
      check_bc("bc_rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_id_clr();
        check_bc("bc_rand_clr");
      end
    end

    // Reset in the middle of both frames
    uart_send(8'h81, 1'b1);
    model_uart(8'h81);
    bc_send(8'h33, 200);
    model_bc(8'h33);
    check_uart("pre_reset");
    check_bc("pre_reset");
    RX = 1'b0;
    BC = 1'b0;
    repeat (3 * BAUD_DIV) @(negedge clk);
    rst_n = 1'b0;
    exp_rdy = 1'b0; exp_data = 8'h00; exp_vld = 1'b0; exp_id = 8'h00;
    @(negedge clk);
    check_uart("mid_frame_reset");
    check_bc("mid_frame_reset");
    repeat (3) @(negedge clk);
    RX = 1'b1;
    BC = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    uart_send(8'h5A, 1'b1);
    model_uart(8'h5A);
    check_uart("post_reset_uart");
    bc_send(8'h21, 240);
    model_bc(8'h21);
    check_bc("post_reset_bc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
